// File: rtl/adc_capture_deadlock_reporter.sv
// Confirms a persistent adc_capture dataflow stall and reports one event record per episode.
// Optional timestamp capture is built when ADC_CAPTURE_DEADLOCK_TIMESTAMP_EN is defined.
module adc_capture_deadlock_reporter #(
    parameter int unsigned INFO_W         = 4,
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TS_W           = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block,
    input  logic [INFO_W-1:0] axis_block_info,
    input  logic              clear,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [INFO_W-1:0] report_info,
    output logic [CNT_W-1:0]  report_count,
    output logic [TS_W-1:0]   report_ts,
    output logic              deadlock,
    output logic              irq
);

    localparam int unsigned CC_W = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CC_W-1:0]   r_confirm_cnt;
    logic [CC_W-1:0]   w_confirm_cnt_next;
    logic              w_confirm;
    logic              w_handshake;
    logic [CNT_W-1:0]  r_episode;
    logic [CNT_W-1:0]  w_episode_next;
    logic              r_report_valid;
    logic [INFO_W-1:0] r_report_info;
    logic [CNT_W-1:0]  r_report_count;
    logic              r_deadlock;
    logic              r_irq;

    // Next-state and confirm detection
    always_comb begin
        w_state_next       = r_state;
        w_confirm_cnt_next = r_confirm_cnt;
        w_confirm          = 1'b0;
        w_handshake        = r_report_valid & report_ready;
        case (r_state)
            S_IDLE: begin
                if (block) begin
                    if (CONFIRM_CYCLES == 1) begin
                        w_confirm    = 1'b1;
                        w_state_next = S_REPORT;
                    end else begin
                        w_state_next       = S_CONFIRM;
                        w_confirm_cnt_next = CC_W'(1);
                    end
                end
            end
            S_CONFIRM: begin
                if (!block) begin
                    w_state_next       = S_IDLE;
                    w_confirm_cnt_next = '0;
                end else if (CC_W'(r_confirm_cnt + CC_W'(1)) == CC_W'(CONFIRM_CYCLES)) begin
                    w_confirm          = 1'b1;
                    w_state_next       = S_REPORT;
                    w_confirm_cnt_next = '0;
                end else begin
                    w_confirm_cnt_next = CC_W'(r_confirm_cnt + CC_W'(1));
                end
            end
            S_REPORT: begin
                if (w_handshake) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!block) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next       = S_IDLE;
                w_confirm_cnt_next = '0;
            end
        endcase
    end

    // A clear coinciding with a confirm restarts the episode count at one
    always_comb begin
        w_episode_next = r_episode;
        if (clear) begin
            w_episode_next = CNT_W'(1);
        end else if (!(&r_episode)) begin
            w_episode_next = CNT_W'(r_episode + CNT_W'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_confirm_cnt  <= '0;
            r_episode      <= '0;
            r_report_valid <= 1'b0;
            r_report_info  <= '0;
            r_report_count <= '0;
            r_deadlock     <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_confirm_cnt <= w_confirm_cnt_next;
            r_irq         <= w_confirm;
            if (w_confirm) begin
                r_report_valid <= 1'b1;
                r_report_info  <= axis_block_info;
                r_episode      <= w_episode_next;
                r_report_count <= w_episode_next;
                r_deadlock     <= 1'b1;
            end else begin
                if (w_handshake) begin
                    r_report_valid <= 1'b0;
                end
                if (clear) begin
                    r_deadlock <= 1'b0;
                    r_episode  <= '0;
                end
            end
        end
    end

`ifdef ADC_CAPTURE_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_report_ts;

    // Free-running timestamp, captured on the confirming sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts        <= '0;
            r_report_ts <= '0;
        end else begin
            r_ts <= TS_W'(r_ts + TS_W'(1));
            if (w_confirm) begin
                r_report_ts <= r_ts;
            end
        end
    end

    assign report_ts = r_report_ts;
`else
    assign report_ts = '0;
`endif

    assign report_valid = r_report_valid;
    assign report_info  = r_report_info;
    assign report_count = r_report_count;
    assign deadlock     = r_deadlock;
    assign irq          = r_irq;

endmodule

// File: tb/tb_adc_capture_deadlock_reporter.sv
// Directed self-checking bench for adc_capture_deadlock_reporter (default config plus a CNT_W=2, CONFIRM_CYCLES=1 instance).
module tb_adc_capture_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset;
    logic        block;
    logic [3:0]  info;
    logic        clear;
    logic        report_ready;
    logic        report_valid;
    logic [3:0]  report_info;
    logic [15:0] report_count;
    logic [31:0] report_ts;
    logic        deadlock;
    logic        irq;

    logic        s_block;
    logic        s_ready;
    logic        s_clear;
    logic        s_valid;
    logic [3:0]  s_info;
    logic [1:0]  s_count;
    logic [31:0] s_ts;
    logic        s_deadlock;
    logic        s_irq;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          irq_seen;
    int          valid_seen;
    logic [31:0] ts_model;
    logic [31:0] exp_ts;
    logic [15:0] rec_count;

    always #5 clock = ~clock;

    // Expected timestamp: cycles elapsed since reset was last sampled high
    always @(posedge clock) begin
        if (reset) ts_model <= 32'd0;
        else       ts_model <= ts_model + 32'd1;
    end

    adc_capture_deadlock_reporter u_dut (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_info (info),
        .clear           (clear),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_info     (report_info),
        .report_count    (report_count),
        .report_ts       (report_ts),
        .deadlock        (deadlock),
        .irq             (irq)
    );

    adc_capture_deadlock_reporter #(
        .INFO_W         (4),
        .CONFIRM_CYCLES (1),
        .CNT_W          (2),
        .TS_W           (32)
    ) u_sat (
        .clock           (clock),
        .reset           (reset),
        .block           (s_block),
        .axis_block_info (4'h3),
        .clear           (s_clear),
        .report_valid    (s_valid),
        .report_ready    (s_ready),
        .report_info     (s_info),
        .report_count    (s_count),
        .report_ts       (s_ts),
        .deadlock        (s_deadlock),
        .irq             (s_irq)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ts_exp(input logic [31:0] t);
`ifdef ADC_CAPTURE_DEADLOCK_TIMESTAMP_EN
        return t;
`else
        return 32'd0 & t;
`endif
    endfunction

    initial begin
        reset = 1'b1; block = 1'b0; info = 4'h0; clear = 1'b0; report_ready = 1'b0;
        s_block = 1'b0; s_ready = 1'b1; s_clear = 1'b0;
        exp_ts = 32'd0; rec_count = 16'd0;
        repeat (3) tick();
        chk("rst_valid", 32'(report_valid), 32'd0);
        chk("rst_info", 32'(report_info), 32'd0);
        chk("rst_count", 32'(report_count), 32'd0);
        chk("rst_ts", report_ts, 32'd0);
        chk("rst_deadlock", 32'(deadlock), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_sat_valid", 32'(s_valid), 32'd0);
        reset = 1'b0;

        // Basic confirm: 16 high samples, report on the 16th edge
        report_ready = 1'b1; info = 4'hE; block = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_ts = ts_exp(ts_model);
            tick();
            if (i < 15) chk("basic_early_valid", 32'(report_valid), 32'd0);
        end
        chk("basic_valid", 32'(report_valid), 32'd1);
        chk("basic_irq", 32'(irq), 32'd1);
        chk("basic_deadlock", 32'(deadlock), 32'd1);
        chk("basic_info", 32'(report_info), 32'hE);
        chk("basic_count", 32'(report_count), 32'd1);
        chk("basic_ts", report_ts, exp_ts);
        block = 1'b0;
        tick();
        chk("basic_valid_drop", 32'(report_valid), 32'd0);
        chk("basic_irq_drop", 32'(irq), 32'd0);
        chk("basic_deadlock_sticky", 32'(deadlock), 32'd1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_deadlock", 32'(deadlock), 32'd0);

        // Glitch rejection: 15 high, 1 low, 15 high
        irq_seen = 0; valid_seen = 0;
        for (int i = 0; i < 31; i++) begin
            block = (i != 15);
            tick();
            irq_seen += int'(irq);
            valid_seen += int'(report_valid);
        end
        block = 1'b0;
        repeat (3) begin
            tick();
            irq_seen += int'(irq);
            valid_seen += int'(report_valid);
        end
        chk("glitch_irq", 32'(irq_seen), 32'd0);
        chk("glitch_valid", 32'(valid_seen), 32'd0);
        chk("glitch_deadlock", 32'(deadlock), 32'd0);

        // Backpressure with changing info and a clear during REPORT
        report_ready = 1'b0; info = 4'h5; block = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_ts = ts_exp(ts_model);
            tick();
        end
        chk("bp_valid", 32'(report_valid), 32'd1);
        chk("bp_irq", 32'(irq), 32'd1);
        chk("bp_info", 32'(report_info), 32'h5);
        chk("bp_count", 32'(report_count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            info = 4'(i) ^ 4'hA;
            clear = (i == 3);
            tick();
            clear = 1'b0;
            chk("bp_hold_valid", 32'(report_valid), 32'd1);
            chk("bp_hold_info", 32'(report_info), 32'h5);
            chk("bp_hold_count", 32'(report_count), 32'd1);
            chk("bp_hold_ts", report_ts, exp_ts);
            if (i == 0) chk("bp_irq_once", 32'(irq), 32'd0);
            if (i == 3) chk("bp_clear_deadlock", 32'(deadlock), 32'd0);
        end
        report_ready = 1'b1;
        tick();
        chk("bp_accept", 32'(report_valid), 32'd0);

        // One record per 200-cycle stall, then a second episode
        block = 1'b0;
        tick();
        block = 1'b1; irq_seen = 0; valid_seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            irq_seen += int'(irq);
            valid_seen += int'(report_valid);
            if (irq) rec_count = report_count;
        end
        chk("ep_irq_once", 32'(irq_seen), 32'd1);
        chk("ep_valid_once", 32'(valid_seen), 32'd1);
        chk("ep_count1", 32'(rec_count), 32'd1);
        block = 1'b0;
        tick();
        block = 1'b1;
        repeat (16) tick();
        chk("ep2_valid", 32'(report_valid), 32'd1);
        chk("ep2_count", 32'(report_count), 32'd2);
        block = 1'b0;
        tick();
        tick();

        // Clear coincident with confirm: confirm wins, count restarts at 1
        report_ready = 1'b0; block = 1'b1;
        for (int i = 0; i < 16; i++) begin
            clear = (i == 15);
            tick();
        end
        clear = 1'b0;
        chk("cc_deadlock", 32'(deadlock), 32'd1);
        chk("cc_count", 32'(report_count), 32'd1);
        chk("cc_irq", 32'(irq), 32'd1);

        // Reset mid-report
        reset = 1'b1;
        tick();
        chk("rr_valid", 32'(report_valid), 32'd0);
        chk("rr_count", 32'(report_count), 32'd0);
        chk("rr_info", 32'(report_info), 32'd0);
        chk("rr_deadlock", 32'(deadlock), 32'd0);
        chk("rr_ts", report_ts, 32'd0);
        reset = 1'b0;

        // Reset mid-episode restarts confirmation
        valid_seen = 0;
        repeat (10) begin tick(); valid_seen += int'(report_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) begin tick(); valid_seen += int'(report_valid); end
        chk("re_no_record", 32'(valid_seen), 32'd0);
        block = 1'b0;
        tick();

        // Saturating 2-bit counter with single-cycle confirm
        for (int e = 0; e < 5; e++) begin
            s_block = 1'b1;
            tick();
            chk("sat_valid", 32'(s_valid), 32'd1);
            chk("sat_count", 32'(s_count), (e < 3) ? 32'(e + 1) : 32'd3);
            s_block = 1'b0;
            tick();
            chk("sat_accept", 32'(s_valid), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
